// File: rtl/rr_req_arbiter_16_if.sv
// Handshake/bus bundle for rr_req_arbiter_16.
//   req_in      : request pulses into the sticky pending vector
//   mask        : per-line eligibility (1 = may be granted)
//   grant       : registered one-hot grant, zero when grant_valid is low
//   grant_valid : grant holds a live request
//   grant_ready : consumer accepts the presented grant
//   pending     : registered sticky request vector
//   busy        : grant_valid OR any pending bit
// slave  = arbiter side, master = requester/consumer side.
interface rr_req_arbiter_16_if;
  logic [15:0] req_in;
  logic [15:0] mask;
  logic [15:0] grant;
  logic        grant_valid;
  logic        grant_ready;
  logic [15:0] pending;
  logic        busy;

  modport slave (
    input  req_in, mask, grant_ready,
    output grant, grant_valid, pending, busy
  );

  modport master (
    output req_in, mask, grant_ready,
    input  grant, grant_valid, pending, busy
  );
endinterface

// File: rtl/rr_req_arbiter_16.sv
// Round-robin arbiter over 16 sticky request lines, feeding encoder_16_4.
// Issues one request at a time as a registered one-hot grant, paced by a
// valid/ready handshake. The search pointer advances past each accepted
// index, so a continuously pending eligible line is served within 16 accepts.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : rr_req_arbiter_16_if.slave (req_in, mask, grant_ready in;
//          grant, grant_valid, pending, busy out)
module rr_req_arbiter_16 #(
  parameter int N  = 16,
  parameter int PW = 4
) (
  input logic                 clk,
  input logic                 rst,
  rr_req_arbiter_16_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_grant, w_grant_nxt;
  logic [N-1:0]    r_pending, w_pending_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;

  logic            w_accept;
  logic [N-1:0]    w_clr;
  logic [N-1:0]    w_cand;
  logic [N-1:0]    w_pick;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_ptr_inc;

  // Rotate the candidates right by ptr so the search start sits at bit 0,
  // isolate the lowest set bit, then rotate back left by ptr.
  function automatic logic [N-1:0] pick(input logic [N-1:0]  cand,
                                        input logic [PW-1:0] ptr);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   iso;
    dbl = {cand, cand} >> ptr;
    rot = dbl[N-1:0];
    iso = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
    dbl = {iso, iso} << ptr;
    return dbl[2*N-1:N];
  endfunction

  // Grant is one-hot, so OR-ing the indices of set bits yields its index.
  function automatic logic [PW-1:0] onehot_idx(input logic [N-1:0] g);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) idx = idx | PW'(i);
    end
    return idx;
  endfunction

  assign w_gidx    = onehot_idx(r_grant);
  assign w_ptr_inc = w_gidx + PW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_pick        = '0;
    w_accept      = (r_state == GRANT) && bus.grant_ready;
    w_clr         = w_accept ? r_grant : '0;
    // A line re-requested in its accept cycle survives via the OR with req_in.
    w_pending_nxt = (r_pending & ~w_clr) | bus.req_in;
    w_cand        = w_pending_nxt & bus.mask;

    case (r_state)
      IDLE: begin
        w_pick = pick(w_cand, r_ptr);
        if (|w_pick) begin
          w_grant_nxt = w_pick;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Without accept the presented grant is frozen regardless of mask/req.
        if (w_accept) begin
          w_ptr_nxt = w_ptr_inc;
          w_pick    = pick(w_cand, w_ptr_inc);
          if (|w_pick) begin
            w_grant_nxt = w_pick;
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_pending <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_pending <= w_pending_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = (r_state == GRANT);
  assign bus.pending     = r_pending;
  assign bus.busy        = (r_state == GRANT) || (|r_pending);

endmodule

// File: tb/tb_rr_req_arbiter_16.sv
module tb_rr_req_arbiter_16;

  logic clk;
  logic rst;

  rr_req_arbiter_16_if u_if ();

  rr_req_arbiter_16 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] g;
    logic        gv;
    logic [15:0] p;
    logic        b;
  } exp_t;

  exp_t sb[$];

  int n_vec;
  int n_err;

  // Reference model state
  logic [15:0] m_grant;
  logic        m_gv;
  logic [15:0] m_pend;
  int          m_ptr;

  // Last observed DUT outputs
  logic [15:0] o_g;
  logic        o_gv;
  logic [15:0] o_p;
  logic        o_b;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_pick(input logic [15:0] cand, input int start);
    for (int k = 0; k < 16; k++) begin
      int j;
      j = (start + k) % 16;
      if (cand[j]) return 16'(1) << j;
    end
    return 16'h0000;
  endfunction

  function automatic int m_idx(input logic [15:0] g);
    for (int i = 0; i < 16; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic void m_reset();
    m_grant = 16'h0;
    m_gv    = 1'b0;
    m_pend  = 16'h0;
    m_ptr   = 0;
  endfunction

  // Advance the model by one edge with the given inputs; push expected outputs.
  function automatic void m_step(input logic [15:0] r, input logic [15:0] m, input logic rdy);
    logic        acc;
    logic [15:0] clr;
    logic [15:0] cand;
    logic [15:0] p;
    exp_t        e;
    acc  = m_gv & rdy;
    clr  = acc ? m_grant : 16'h0;
    m_pend = (m_pend & ~clr) | r;
    cand = m_pend & m;
    if (!m_gv) begin
      p = m_pick(cand, m_ptr);
      if (p != 16'h0) begin
        m_grant = p;
        m_gv    = 1'b1;
      end
    end else if (acc) begin
      m_ptr = (m_idx(m_grant) + 1) % 16;
      p = m_pick(cand, m_ptr);
      if (p != 16'h0) begin
        m_grant = p;
      end else begin
        m_grant = 16'h0;
        m_gv    = 1'b0;
      end
    end
    e.g  = m_grant;
    e.gv = m_gv;
    e.p  = m_pend;
    e.b  = m_gv | (m_pend != 16'h0);
    sb.push_back(e);
  endfunction

  // Called at a negedge: drive inputs, clock once, compare against scoreboard.
  task automatic step(input logic [15:0] r, input logic [15:0] m, input logic rdy);
    exp_t e;
    u_if.req_in      = r;
    u_if.mask        = m;
    u_if.grant_ready = rdy;
    m_step(r, m, rdy);
    @(posedge clk);
    #1;
    o_g  = u_if.grant;
    o_gv = u_if.grant_valid;
    o_p  = u_if.pending;
    o_b  = u_if.busy;
    e = sb.pop_front();
    chk_eq("sb_grant",   32'(o_g),  32'(e.g));
    chk_eq("sb_valid",   32'(o_gv), 32'(e.gv));
    chk_eq("sb_pending", 32'(o_p),  32'(e.p));
    chk_eq("sb_busy",    32'(o_b),  32'(e.b));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_if.req_in      = 16'h0;
    u_if.mask        = 16'hFFFF;
    u_if.grant_ready = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    u_if.req_in      = 16'h0;
    u_if.mask        = 16'hFFFF;
    u_if.grant_ready = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk_eq("rst_grant",   32'(u_if.grant),       32'h0);
    chk_eq("rst_valid",   32'(u_if.grant_valid), 32'h0);
    chk_eq("rst_pending", 32'(u_if.pending),     32'h0);
    chk_eq("rst_busy",    32'(u_if.busy),        32'h0);
    rst = 1'b0;

    // Single request
    step(16'h0001, 16'hFFFF, 1'b1);
    chk_eq("single_grant", 32'(o_g),  32'h0001);
    chk_eq("single_valid", 32'(o_gv), 32'h1);
    chk_eq("single_idx",   32'(m_idx(o_g)), 32'd0);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("single_done_valid",   32'(o_gv), 32'h0);
    chk_eq("single_done_pending", 32'(o_p),  32'h0);
    chk_eq("single_done_busy",    32'(o_b),  32'h0);

    // Round-robin order with wrap
    do_reset();
    step(16'h8421, 16'hFFFF, 1'b1);
    chk_eq("rr_g0", 32'(o_g), 32'h0001);
    chk_eq("rr_i0", 32'(m_idx(o_g)), 32'd0);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("rr_g1", 32'(o_g), 32'h0020);
    chk_eq("rr_i1", 32'(m_idx(o_g)), 32'd5);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("rr_g2", 32'(o_g), 32'h0400);
    chk_eq("rr_i2", 32'(m_idx(o_g)), 32'd10);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("rr_g3", 32'(o_g), 32'h8000);
    chk_eq("rr_i3", 32'(m_idx(o_g)), 32'd15);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("rr_end_valid", 32'(o_gv), 32'h0);
    // Pointer wrapped to 0: a fresh 0x8001 request must pick bit 0 first.
    step(16'h8001, 16'hFFFF, 1'b1);
    chk_eq("rr_wrap", 32'(o_g), 32'h0001);
    step(16'h0000, 16'hFFFF, 1'b1);
    step(16'h0000, 16'hFFFF, 1'b1);

    // Stall
    do_reset();
    step(16'h0020, 16'hFFFF, 1'b0);
    chk_eq("stall_g0", 32'(o_g), 32'h0020);
    step(16'h0001, 16'hFFFF, 1'b0);
    chk_eq("stall_g1", 32'(o_g), 32'h0020);
    step(16'h0000, 16'h0000, 1'b0);
    chk_eq("stall_g2", 32'(o_g), 32'h0020);
    step(16'h0000, 16'hFFFF, 1'b0);
    chk_eq("stall_g3", 32'(o_g), 32'h0020);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("stall_next", 32'(o_g), 32'h0001);
    step(16'h0000, 16'hFFFF, 1'b1);

    // Masking
    do_reset();
    step(16'h0003, 16'hFFFE, 1'b1);
    chk_eq("mask_g", 32'(o_g), 32'h0002);
    step(16'h0000, 16'hFFFE, 1'b1);
    chk_eq("mask_valid", 32'(o_gv), 32'h0);
    chk_eq("mask_pend",  32'(o_p),  32'h0001);
    chk_eq("mask_busy",  32'(o_b),  32'h1);
    step(16'h0000, 16'hFFFE, 1'b1);
    chk_eq("mask_hold_valid", 32'(o_gv), 32'h0);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("unmask_g", 32'(o_g), 32'h0001);
    step(16'h0000, 16'hFFFF, 1'b1);

    // Re-request on accept
    do_reset();
    step(16'h0018, 16'hFFFF, 1'b0);
    chk_eq("rereq_g0", 32'(o_g), 32'h0008);
    step(16'h0008, 16'hFFFF, 1'b1);
    chk_eq("rereq_pend3", 32'(o_p[3]), 32'h1);
    chk_eq("rereq_g1",    32'(o_g),    32'h0010);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("rereq_g2", 32'(o_g), 32'h0008);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("rereq_idle", 32'(o_gv), 32'h0);

    // Asynchronous reset mid-grant
    step(16'hFFFF, 16'hFFFF, 1'b0);
    chk_eq("arst_pre_valid", 32'(o_gv), 32'h1);
    chk_eq("arst_pre_pend",  32'(o_p),  32'hFFFF);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_eq("arst_grant",   32'(u_if.grant),       32'h0);
    chk_eq("arst_valid",   32'(u_if.grant_valid), 32'h0);
    chk_eq("arst_pending", 32'(u_if.pending),     32'h0);
    chk_eq("arst_busy",    32'(u_if.busy),        32'h0);
    repeat (2) @(negedge clk);
    m_reset();
    u_if.req_in = 16'h0;
    rst = 1'b0;
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("arst_after0", 32'(o_gv), 32'h0);
    step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("arst_after1", 32'(o_gv), 32'h0);

    // All masked: pending accumulates, nothing granted
    step(16'h0300, 16'h0000, 1'b1);
    step(16'h0005, 16'h0000, 1'b1);
    chk_eq("allmask_valid", 32'(o_gv), 32'h0);
    chk_eq("allmask_pend",  32'(o_p),  32'h0305);
    chk_eq("allmask_busy",  32'(o_b),  32'h1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [15:0] r;
      logic [15:0] m;
      logic        rdy;
      r   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      m   = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'hFFFF;
      rdy = ($urandom_range(0, 2) != 0);
      step(r, m, rdy);
    end

    // Drain
    for (int n = 0; n < 20; n++) step(16'h0000, 16'hFFFF, 1'b1);
    chk_eq("drain_busy", 32'(o_b), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
